// File: rtl/scan_source_mux_pkg.sv
// Shared types and sizing helpers for the scanning display source selector
// and the display blocks that reuse its channel picker.
package scan_mux_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   typedef enum logic {
      SHOW = 1'b0,
      BLNK = 1'b1
   } state_t;

   // Channel index width; a single-channel build still needs a 1-bit port.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a counter that must hold values 0..max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/ch_rotate_pick.sv
// Wrap-around priority search: first enabled channel after cur_ch, in the
// order cur_ch+1, cur_ch+2, ... modulo N_CH. cur_ch itself is never picked.
module ch_rotate_pick
   import scan_mux_pkg::*;
#(
   parameter  int N_CH = 4,
   localparam int CW   = ch_width(N_CH)
) (
   input  logic [CW-1:0]   cur_ch,
   input  logic [N_CH-1:0] ch_mask,
   output logic [CW-1:0]   next_ch,
   output logic            found
);

   localparam logic [CW:0] N_CH_W = (CW+1)'(N_CH);

   logic [2*N_CH-1:0] rot;
   logic [CW:0]       cand;

   // NOTE: every signal driven here gets a default before any branch, so the
   // block stays purely combinational and no latch can be inferred.
   always_comb begin
      rot     = {ch_mask, ch_mask} >> cur_ch;
      next_ch = cur_ch;
      found   = 1'b0;
      cand    = '0;
      for (int off = 1; off < N_CH; off++) begin
         if (!found && rot[off]) begin
            found = 1'b1;
            cand  = {1'b0, cur_ch} + (CW+1)'(off);
            if (cand >= N_CH_W) begin
               cand = cand - N_CH_W;
            end
            next_ch = cand[CW-1:0];
         end
      end
   end

endmodule

// File: rtl/scan_source_mux.sv
// N-channel display source selector: manual or auto-scanning channel choice,
// registered output, and zero-output blanking on every channel change.
module scan_source_mux
   import scan_mux_pkg::*;
#(
   parameter  int WIDTH = 3,
   parameter  int N_CH  = 4,
   parameter  int DWELL = 16,
   parameter  int BLANK = 2,
   localparam int CW    = ch_width(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mode,
   input  logic [CW-1:0]         sel,
   input  logic                  en,
   input  logic [N_CH-1:0]       ch_mask,
   input  logic [N_CH*WIDTH-1:0] din,
   output logic [WIDTH-1:0]      result,
   output logic [CW-1:0]         cur_ch,
   output logic                  blanking
);

   localparam int DW = cnt_width(DWELL);
   localparam int BW = cnt_width(BLANK);

   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
   localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK > 0) ? BLANK - 1 : 0);
   localparam logic [CW:0]   N_CH_W     = (CW+1)'(N_CH);

   state_t           state_q, state_d;
   logic [CW-1:0]    cur_q, cur_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             blank_q, blank_d;
   logic [DW-1:0]    dwell_q, dwell_d;
   logic [BW-1:0]    cnt_q, cnt_d;
   logic             mode_q;

   logic [WIDTH-1:0] src [N_CH];
   logic [CW-1:0]    pick_ch;
   logic             pick_found;
   logic [CW-1:0]    target;
   logic             scan_entry;

   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         src[k] = din[k*WIDTH +: WIDTH];
      end
   end

   ch_rotate_pick #(
      .N_CH (N_CH)
   ) u_pick (
      .cur_ch  (cur_q),
      .ch_mask (ch_mask),
      .next_ch (pick_ch),
      .found   (pick_found)
   );

   // Target selection: exactly one source (sel or scan expiry) per mode.
   always_comb begin
      target     = cur_q;
      dwell_d    = dwell_q;
      scan_entry = (mode == MODE_SCAN) && (mode_q == MODE_MANUAL);
      if (mode == MODE_MANUAL) begin
         dwell_d = '0;
         if ({1'b0, sel} < N_CH_W) begin
            target = sel;
         end
      end else if (scan_entry) begin
         dwell_d = '0;
      end else if (state_q == SHOW && en) begin
         if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            if (pick_found) begin
               target = pick_ch;
            end
         end else begin
            dwell_d = dwell_q + 1'b1;
         end
      end
   end

   // A new target always wins, even on the last blanking cycle, so the
   // output never shows data from a channel that was only briefly requested.
   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      result_d = result_q;
      blank_d  = blank_q;
      cnt_d    = cnt_q;
      if (target != cur_q) begin
         cur_d = target;
         if (BLANK > 0) begin
            state_d  = BLNK;
            cnt_d    = '0;
            result_d = '0;
            blank_d  = 1'b1;
         end else begin
            state_d  = SHOW;
            result_d = src[target];
            blank_d  = 1'b0;
         end
      end else if (state_q == BLNK) begin
         if (cnt_q == BLANK_LAST) begin
            state_d  = SHOW;
            cnt_d    = '0;
            result_d = src[cur_q];
            blank_d  = 1'b0;
         end else begin
            cnt_d    = cnt_q + 1'b1;
            result_d = '0;
            blank_d  = 1'b1;
         end
      end else begin
         result_d = src[cur_q];
         blank_d  = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= SHOW;
         cur_q    <= '0;
         result_q <= '0;
         blank_q  <= 1'b0;
         dwell_q  <= '0;
         cnt_q    <= '0;
         mode_q   <= MODE_MANUAL;
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         result_q <= result_d;
         blank_q  <= blank_d;
         dwell_q  <= dwell_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode;
      end
   end

   assign result   = result_q;
   assign cur_ch   = cur_q;
   assign blanking = blank_q;

endmodule

// File: tb/tb_scan_source_mux.sv
// Directed bench for scan_source_mux: per-cycle expected outputs are queued
// as stimulus is applied and compared after the following clock edge.
module tb_scan_source_mux;
   import scan_mux_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       mode;
   logic       en;
   logic [3:0] ch_mask;
   logic [1:0] sel, sel3, sel0;

   logic [11:0] din  = 12'b111_100_010_001;
   logic [8:0]  din3 = 9'b100_010_001;

   logic [2:0] result,  result3,  result0;
   logic [1:0] cur_ch,  cur3,     cur0;
   logic       blanking, blank3,  blank0;

   localparam logic [2:0] SRC [4] = '{3'b001, 3'b010, 3'b100, 3'b111};

   typedef struct packed {
      logic [2:0] res;
      logic [1:0] ch;
      logic       blk;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   scan_source_mux #(.WIDTH(3), .N_CH(4), .DWELL(4), .BLANK(2)) dut (
      .clk(clk), .rst(rst), .mode(mode), .sel(sel), .en(en),
      .ch_mask(ch_mask), .din(din),
      .result(result), .cur_ch(cur_ch), .blanking(blanking)
   );

   scan_source_mux #(.WIDTH(3), .N_CH(3), .DWELL(4), .BLANK(2)) dut3 (
      .clk(clk), .rst(rst), .mode(mode), .sel(sel3), .en(en),
      .ch_mask(ch_mask[2:0]), .din(din3),
      .result(result3), .cur_ch(cur3), .blanking(blank3)
   );

   scan_source_mux #(.WIDTH(3), .N_CH(4), .DWELL(4), .BLANK(0)) dut0 (
      .clk(clk), .rst(rst), .mode(mode), .sel(sel0), .en(en),
      .ch_mask(ch_mask), .din(din),
      .result(result0), .cur_ch(cur0), .blanking(blank0)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic [2:0] r, input logic [1:0] c,
                       input logic b);
      exp_t e;
      sb.push_back('{res: r, ch: c, blk: b});
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      chk({tag, ".result"},   8'(result),   8'(e.res));
      chk({tag, ".cur_ch"},   8'(cur_ch),   8'(e.ch));
      chk({tag, ".blanking"}, 8'(blanking), 8'(e.blk));
   endtask

   task automatic visit(input string tag, input int ch);
      repeat (2) step({tag, "_blank"}, 3'b000, 2'(ch), 1'b1);
      repeat (4) step({tag, "_show"}, SRC[ch], 2'(ch), 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seq_full [4] = '{1, 2, 3, 0};
      int seq_odd  [4] = '{1, 3, 1, 3};

      rst = 1'b0; mode = MODE_MANUAL; en = 1'b0; ch_mask = 4'b0000;
      sel = 2'd0; sel3 = 2'd0; sel0 = 2'd0;
      repeat (2) @(negedge clk);
      chk("reset.result",   8'(result),   8'h00);
      chk("reset.cur_ch",   8'(cur_ch),   8'h00);
      chk("reset.blanking", 8'(blanking), 8'h00);

      rst = 1'b1;
      step("rst_release", 3'b001, 2'd0, 1'b0);
      chk("n3.rst_result", 8'(result3), 8'h01);
      chk("b0.rst_result", 8'(result0), 8'h01);

      // Manual switch 0 -> 2; the 3-channel build ignores sel=3.
      sel = 2'd2; sel3 = 2'd3;
      step("man_sw", 3'b000, 2'd2, 1'b1);
      chk("n3.ignore_cur",   8'(cur3),   8'h00);
      chk("n3.ignore_blank", 8'(blank3), 8'h00);
      step("man_sw", 3'b000, 2'd2, 1'b1);
      chk("n3.ignore_result", 8'(result3), 8'h01);
      step("man_show", 3'b100, 2'd2, 1'b0);
      step("man_show", 3'b100, 2'd2, 1'b0);

      // Zero-blank build: data changes on consecutive cycles.
      sel0 = 2'd1;
      step("man_hold", 3'b100, 2'd2, 1'b0);
      chk("b0.first_result", 8'(result0), 8'h02);
      chk("b0.first_cur",    8'(cur0),    8'h01);
      chk("b0.first_blank",  8'(blank0),  8'h00);
      sel0 = 2'd2;
      step("man_hold", 3'b100, 2'd2, 1'b0);
      chk("b0.next_result", 8'(result0), 8'h04);
      chk("b0.next_cur",    8'(cur0),    8'h02);
      chk("b0.next_blank",  8'(blank0),  8'h00);

      // Asynchronous reset observed before any clock edge.
      rst = 1'b0;
      #1;
      chk("async_rst.result",   8'(result),   8'h00);
      chk("async_rst.cur_ch",   8'(cur_ch),   8'h00);
      chk("async_rst.blanking", 8'(blanking), 8'h00);
      sel = 2'd0; sel3 = 2'd0; sel0 = 2'd0;
      @(negedge clk);
      rst = 1'b1;
      step("rst2_release", 3'b001, 2'd0, 1'b0);

      // Scan through all channels, including the 3 -> 0 wrap.
      mode = MODE_SCAN; en = 1'b1; ch_mask = 4'b1111;
      repeat (4) step("scan_ch0", 3'b001, 2'd0, 1'b0);
      foreach (seq_full[i]) visit("scan_all", seq_full[i]);

      // Sparse mask skips disabled channels.
      ch_mask = 4'b1010;
      foreach (seq_odd[i]) visit("scan_odd", seq_odd[i]);

      // Empty mask: expiry keeps the current channel, no blanking.
      ch_mask = 4'b0000;
      repeat (4) step("scan_empty", 3'b111, 2'd3, 1'b0);

      // Enable low freezes the dwell counter; it resumes at its held value.
      en = 1'b0; ch_mask = 4'b1111;
      repeat (10) step("scan_frozen", 3'b111, 2'd3, 1'b0);
      en = 1'b1;
      repeat (2) step("scan_resume_blank", 3'b000, 2'd0, 1'b1);
      repeat (2) step("scan_resume_show", 3'b001, 2'd0, 1'b0);

      // Back to manual, then a second request while blanking.
      mode = MODE_MANUAL; sel = 2'd0;
      step("man_back", 3'b001, 2'd0, 1'b0);
      sel = 2'd1;
      step("mid_blank_a", 3'b000, 2'd1, 1'b1);
      step("mid_blank_a", 3'b000, 2'd1, 1'b1);
      sel = 2'd3;
      step("mid_blank_b", 3'b000, 2'd3, 1'b1);
      step("mid_blank_b", 3'b000, 2'd3, 1'b1);
      step("mid_show", 3'b111, 2'd3, 1'b0);
      step("mid_show", 3'b111, 2'd3, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/scan_source_mux.md
Name: scan_source_mux

Overview:
- N-channel successor to the two-source dice/traffic-light output selector.
- Drives one WIDTH-bit display bus from N_CH packed source buses.
- MANUAL mode: select input picks the channel. SCAN mode: block auto-rotates through enabled channels every DWELL cycles.
- Registered output. Channel changes insert BLANK cycles of all-zero output so the LED display never shows a mix of two sources.

Parameters:
- WIDTH, 3: bits per source channel and output.
- N_CH, 4: number of source channels, ≥2.
- DWELL, 16: cycles a channel is shown in SCAN mode before advancing, ≥1.
- BLANK, 2: zero-output cycles inserted on every channel change, ≥0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mode  in  1  0 = MANUAL, 1 = SCAN.
- sel  in  CW = $clog2(N_CH)  MANUAL channel request.
- en  in  1  SCAN advance enable; 0 freezes the dwell counter.
- ch_mask  in  N_CH  per-channel enable for SCAN rotation.
- din  in  N_CH*WIDTH  packed sources; channel k is din[k*WIDTH +: WIDTH].
- result  out  WIDTH  registered selected source.
- cur_ch  out  CW  registered channel currently owning the output.
- blanking  out  1  high while result is forced to zero by a switch.

Behaviour:
- Reset (rst=0, async): result=0, cur_ch=0, blanking=0, state=SHOW, dwell_cnt=0, blank_cnt=0.
- States: SHOW, BLNK. All outputs registered; result lags din by 1 cycle in SHOW.
- SHOW, each cycle: result <= din slice of cur_ch; blanking <= 0.
- Target, MANUAL: target = sel. If sel ≥ N_CH, target = cur_ch (request ignored).
- Target, SCAN:
  - If en=1, dwell_cnt increments.
  - On the cycle dwell_cnt == DWELL-1 with en=1: dwell_cnt <= 0; target = first channel with ch_mask set, searching cur_ch+1, cur_ch+2, … with wrap modulo N_CH.
  - If no channel other than cur_ch is set, target = cur_ch. ch_mask all zero: hold cur_ch.
  - A masked cur_ch stays shown until the next dwell expiry (no immediate jump).
- Switch (target != cur_ch):
  - cur_ch <= target.
  - If BLANK>0: state <= BLNK, blank_cnt <= 0, result <= 0, blanking <= 1.
  - If BLANK==0: stay in SHOW, result <= din slice of target in the same edge.
- BLNK:
  - result=0, blanking=1; blank_cnt increments; dwell_cnt frozen.
  - After BLANK cycles total at zero, state <= SHOW. The first SHOW edge loads the new channel's data.
- New switch during BLNK (MANUAL sel change, or mode change producing a different target): cur_ch <= new target, blank_cnt restarts at 0. Output stays zero, with no intermediate data.
- Mode MANUAL→SCAN: dwell_cnt <= 0; no switch until the first expiry.
- Mode SCAN→MANUAL: sel is evaluated on the same cycle; a switch follows if it differs.
- Simultaneous MANUAL request and scan expiry cannot occur: mode selects exactly one target source.
- dwell_cnt width $clog2(DWELL+1); blank_cnt width $clog2(BLANK+1); no overflow, since counters reset at their terminal value.
- Reset mid-BLNK or mid-dwell: immediate return to reset values; cur_ch=0 with no blanking.

Decomposition:
- Package scan_mux_pkg:
  - MODE_MANUAL=1'b0, MODE_SCAN=1'b1.
  - State enum {SHOW, BLNK}.
  - Function for CW = $clog2(N_CH).
- Sub-module ch_rotate_pick (combinational):
  - Inputs: cur_ch, ch_mask. Outputs: next_ch, found.
  - Wrap-around priority search from cur_ch+1; reused by other display blocks.
- Top holds the FSM, both counters, output registers and the din slice mux.

Test Plan (WIDTH=3, N_CH=4, DWELL=4, BLANK=2, din ch0..3 = 3'b001, 3'b010, 3'b100, 3'b111):
- Reset then MANUAL, sel=0 -> one cycle after rst release: result=001, cur_ch=0, blanking=0. Assert rst=0 mid-run -> outputs 0 asynchronously, before the next clk edge.
- MANUAL, sel 0→2 -> next edge: cur_ch=2, result=000, blanking=1 for exactly 2 cycles, then result=100. sel=5 is unreachable with CW=2; rebuild with N_CH=3 and sel=3 -> ignored, cur_ch holds.
- SCAN, ch_mask=4'b1111, en=1 -> channels 0,1,2,3,0 in order. Each switch = 2 zero cycles; each SHOW lasts 4 counted cycles; wrap 3→0 verified.
- SCAN, ch_mask=4'b1010, cur_ch=0 -> sequence 1,3,1,3. ch_mask=4'b0000 -> cur_ch frozen with no blanking. en=0 for 10 cycles -> no advance; counter resumes on en=1.
- MANUAL, sel 0→1, then sel→3 on the 2nd BLNK cycle -> blanking extends to 2 cycles after the second change, no 010 ever visible, final result=111, cur_ch=3.
- Rebuild with BLANK=0, MANUAL, sel 1→2 -> result goes 010→100 on consecutive cycles, blanking never asserted.
